// File: rtl/traffic_phase_arbiter_if.sv
// Request/lamp bundle for traffic_phase_arbiter.
// TRAFFIC_PREEMPT_EN adds the emergency preemption inputs pre_req/pre_sel.
interface traffic_phase_arbiter_if;
    logic [3:0] req;
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
    logic [3:0] grant;
    logic [3:0] pend;
    logic       phase_done;
`ifdef TRAFFIC_PREEMPT_EN
    logic       pre_req;
    logic [1:0] pre_sel;

    modport slave (input req, pre_req, pre_sel,
                   output m1, m2, mt, s, grant, pend, phase_done);
    modport master (output req, pre_req, pre_sel,
                    input m1, m2, mt, s, grant, pend, phase_done);
`else
    modport slave (input req, output m1, m2, mt, s, grant, pend, phase_done);
    modport master (output req, input m1, m2, mt, s, grant, pend, phase_done);
`endif
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Request-driven round-robin phase scheduler for the m1/m2/mt/s lamp set.
// Optional emergency preemption is enabled with TRAFFIC_PREEMPT_EN.
module traffic_phase_arbiter #(
    parameter int T_MIN_GREEN = 7,
    parameter int T_MAX_GREEN = 15,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1,
    parameter int CW          = 5
) (
    input logic clk,
    input logic r,
    traffic_phase_arbiter_if.slave bus
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      cur, rr, sel, cand, go_idx, go_rr;
    logic [3:0]      pend, grant, pend_set;
    logic [3:0][2:0] lamps;
    logic            phase_done, go_any, green_exit, found;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    function automatic logic [3:0][2:0] lamp_vec(input logic [1:0] idx, input logic [2:0] code);
        logic [3:0][2:0] v;
        for (int k = 0; k < 4; k++) v[k] = (2'(k) == idx) ? code : RED;
        return v;
    endfunction

    always_comb begin
        // the approach currently in green is already being served
        pend_set = bus.req & ~((state == GREEN) ? grant : 4'b0000);
        sel   = rr;
        cand  = rr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr + 2'(k);
            if (!found && pend[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        green_exit = (count >= CW'(T_MIN_GREEN - 1)) && (|(pend & ~grant)) &&
                     (!bus.req[cur] || count >= CW'(T_MAX_GREEN - 1));
`ifdef TRAFFIC_PREEMPT_EN
        go_any = bus.pre_req | (|pend);
        go_idx = bus.pre_req ? bus.pre_sel : sel;
        go_rr  = bus.pre_req ? rr : sel;
        if (bus.pre_req) green_exit = (cur != bus.pre_sel);
`else
        go_any = |pend;
        go_idx = sel;
        go_rr  = sel;
`endif
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state      <= IDLE;
            count      <= '0;
            cur        <= '0;
            rr         <= '0;
            pend       <= '0;
            grant      <= '0;
            lamps      <= {4{RED}};
            phase_done <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            pend       <= pend | pend_set;
            case (state)
                IDLE: begin
                    if (go_any) begin
                        state <= GREEN;
                        cur   <= go_idx;
                        rr    <= go_rr;
                        grant <= oh(go_idx);
                        count <= '0;
                        lamps <= lamp_vec(go_idx, GRN);
                        pend  <= (pend | pend_set) & ~oh(go_idx);
                    end
                end
                GREEN: begin
                    if (green_exit) begin
                        state <= YELLOW;
                        count <= '0;
                        lamps <= lamp_vec(cur, YEL);
                    end else if (count < CW'(T_MAX_GREEN - 1)) begin
                        count <= count + 1'b1;
                    end
                end
                YELLOW: begin
                    if (count >= CW'(T_YELLOW - 1)) begin
                        state <= ALLRED;
                        count <= '0;
                        lamps <= {4{RED}};
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ALLRED: begin
                    if (count >= CW'(T_ALLRED - 1)) begin
                        phase_done <= 1'b1;
                        count      <= '0;
                        // chain straight into the next green when anything waits
                        if (go_any) begin
                            state <= GREEN;
                            cur   <= go_idx;
                            rr    <= go_rr;
                            grant <= oh(go_idx);
                            lamps <= lamp_vec(go_idx, GRN);
                            pend  <= (pend | pend_set) & ~oh(go_idx);
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    grant <= '0;
                    lamps <= {4{RED}};
                end
            endcase
        end
    end

    assign bus.m1         = lamps[0];
    assign bus.m2         = lamps[1];
    assign bus.mt         = lamps[2];
    assign bus.s          = lamps[3];
    assign bus.grant      = grant;
    assign bus.pend       = pend;
    assign bus.phase_done = phase_done;
endmodule
